alu_mdu_seq: RTL and testbench

- Parametrised, handshaked execute unit for the RV32I/RV32M core.
- Covers all base integer ALU ops (registered, 1-cycle) and M-extension multiply/divide (iterative, multi-cycle).
- Produces NZCV flags alongside the result.
- Sits in the EX stage and stalls the pipeline through valid/ready while an iterative op runs.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_mdu_seq_if.sv | 26 ++
 rtl/mdu_iter.sv | 111 +++++++++++
 rtl/alu_mdu_seq.sv | 122 ++++++++++++
 tb/tb_alu_mdu_seq.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the execute unit: opcodes, FSM states and the iterative-op predicate.
package alu_pkg;

    typedef enum logic [4:0] {
        ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } op_e;

    typedef enum logic [1:0] {
        IDLE, ITER, DONE
    } state_e;

    function automatic logic is_iter(op_e op);
        return op inside {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/alu_mdu_seq_if.sv
// Request/response bundle between the EX stage and the execute unit.
interface alu_mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      alu_ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            N, Z, C, V;
    logic            busy;

    modport slave (
        input  in_valid, alu_ctrl, a, b, flush, out_ready,
        output in_ready, out_valid, result, N, Z, C, V, busy
    );

    modport master (
        output in_valid, alu_ctrl, a, b, flush, out_ready,
        input  in_ready, out_valid, result, N, Z, C, V, busy
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: XLEN shift-add or restoring steps on operand magnitudes.
// res is valid combinationally in the cycle where last=1; flush or reset clears the counter.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  op_e             op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last,
    output logic [XLEN-1:0] res
);
    // acc holds {hi, lo} for multiply and {remainder, quotient} for divide
    logic [2*XLEN-1:0] acc_q, acc_d, step, prod;
    logic [XLEN-1:0]   opnd_q, opnd_d, a_q, a_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic              neg_q, neg_d, div0_q, div0_d;
    logic              a_neg, b_neg, is_div;
    logic [XLEN-1:0]   mag_a, mag_b, quo, rem;
    logic [XLEN:0]     add_w, rs, diff;

    always_comb begin
        a_neg  = (op inside {MULH, MULHSU, DIV, REM}) && a[XLEN-1];
        b_neg  = (op inside {MULH, DIV, REM}) && b[XLEN-1];
        mag_a  = a_neg ? -a : a;
        mag_b  = b_neg ? -b : b;
        acc_d  = acc_q;
        opnd_d = opnd_q;
        a_d    = a_q;
        op_d   = op_q;
        neg_d  = neg_q;
        div0_d = div0_q;
        cnt_d  = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (start) begin
            cnt_d  = CNT_W'(XLEN);
            op_d   = op;
            a_d    = a;
            div0_d = (b == '0);
            if (op inside {DIV, DIVU, REM, REMU}) begin
                acc_d  = {{XLEN{1'b0}}, mag_a};
                opnd_d = mag_b;
                neg_d  = (op inside {REM, REMU}) ? a_neg : (a_neg ^ b_neg);
            end else begin
                acc_d  = {{XLEN{1'b0}}, mag_b};
                opnd_d = mag_a;
                neg_d  = a_neg ^ b_neg;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            acc_d = step;
        end
    end

    always_comb begin
        is_div = op_q inside {DIV, DIVU, REM, REMU};
        add_w  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rs     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff   = rs - {1'b0, opnd_q};
        if (is_div) begin
            step = diff[XLEN] ? {rs[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            step = {add_w, acc_q[XLEN-1:1]};
        end
    end

    // Sign fix-up applied to the final step so the result is ready on DONE entry
    always_comb begin
        prod = neg_q ? -step : step;
        quo  = step[XLEN-1:0];
        rem  = step[2*XLEN-1:XLEN];
        case (op_q)
            MUL:                 res = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: res = prod[2*XLEN-1:XLEN];
            DIV, DIVU:           res = div0_q ? '1 : (neg_q ? -quo : quo);
            REM, REMU:           res = div0_q ? a_q : (neg_q ? -rem : rem);
            default:             res = '0;
        endcase
    end

    assign last = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            a_q    <= '0;
            op_q   <= ADD;
            neg_q  <= 1'b0;
            div0_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            a_q    <= a_d;
            op_q   <= op_d;
            neg_q  <= neg_d;
            div0_q <= div0_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/alu_mdu_seq.sv
// EX-stage execute unit: base ALU ops in 1 cycle, MUL/DIV in XLEN+1 cycles, NZCV flags.
// Result held in DONE until out_ready; next op accepted in the same cycle it is taken.
module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN),
    parameter int CNT_W   = $clog2(XLEN) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_mdu_seq_if.slave io
);
    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [3:0]      flags_q, flags_d;
    op_e             op;
    logic            in_ready, accept, start, mdu_last;
    logic [XLEN-1:0] mdu_res, alu_res;
    logic            alu_c, alu_v;
    logic [XLEN:0]   add_w, sub_w;

    assign op       = op_e'(io.alu_ctrl);
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && io.out_ready);
    assign accept   = io.in_valid && in_ready && !io.flush;
    assign start    = accept && is_iter(op);

    mdu_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (io.flush),
        .start (start),
        .op    (op),
        .a     (io.a),
        .b     (io.b),
        .last  (mdu_last),
        .res   (mdu_res)
    );

    always_comb begin
        add_w   = {1'b0, io.a} + {1'b0, io.b};
        sub_w   = {1'b0, io.a} - {1'b0, io.b};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            ADD: begin
                alu_res = add_w[XLEN-1:0];
                alu_c   = add_w[XLEN];
                alu_v   = ~(io.a[XLEN-1] ^ io.b[XLEN-1]) & (io.a[XLEN-1] ^ add_w[XLEN-1]);
            end
            SUB: begin
                alu_res = sub_w[XLEN-1:0];
                alu_c   = sub_w[XLEN];
                alu_v   = (io.a[XLEN-1] ^ io.b[XLEN-1]) & (io.a[XLEN-1] ^ sub_w[XLEN-1]);
            end
            XOR:  alu_res = io.a ^ io.b;
            OR:   alu_res = io.a | io.b;
            AND:  alu_res = io.a & io.b;
            SLL:  alu_res = io.a << io.b[SHAMT_W-1:0];
            SRL:  alu_res = io.a >> io.b[SHAMT_W-1:0];
            SRA:  alu_res = $unsigned($signed(io.a) >>> io.b[SHAMT_W-1:0]);
            SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(io.a) < $signed(io.b))};
            SLTU: alu_res = {{(XLEN-1){1'b0}}, (io.a < io.b)};
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        if (io.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        if (is_iter(op)) begin
                            state_d = ITER;
                        end else begin
                            state_d  = DONE;
                            result_d = alu_res;
                            flags_d  = {alu_res[XLEN-1], (alu_res == '0), alu_c, alu_v};
                        end
                    end else if ((state_q == DONE) && io.out_ready) begin
                        state_d = IDLE;
                    end
                end
                ITER: begin
                    if (mdu_last) begin
                        state_d  = DONE;
                        result_d = mdu_res;
                        flags_d  = {mdu_res[XLEN-1], (mdu_res == '0), 2'b00};
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= 4'b0100;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = (state_q == DONE);
    assign io.busy      = (state_q == ITER);
    assign io.result    = result_q;
    assign io.N         = flags_q[3];
    assign io.Z         = flags_q[2];
    assign io.C         = flags_q[1];
    assign io.V         = flags_q[0];
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq: vector table plus handshake, flush and reset sequences.
module tb_alu_mdu_seq;
    import alu_pkg::*;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  nzcv;
        int          lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    vec_t vecs[$];

    alu_mdu_seq_if #(.XLEN(32)) bus();

    alu_mdu_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic [4:0] op, logic [31:0] a, logic [31:0] b,
                                logic [31:0] res, logic [3:0] nzcv, int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.nzcv = nzcv; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, bus.N, bus.Z, bus.C, bus.V};
    endfunction

    task automatic run_vec(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res,
                           input logic [3:0] exp_f, input int exp_lat);
        int lat;
        @(negedge clk);
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.alu_ctrl  = op;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, bus.result, exp_res);
        chk({tag, " nzcv"}, flags(), {28'd0, exp_f});
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        n_cmp = 0;
        n_err = 0;
        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = 5'd0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        //                op       a             b             result        NZCV     lat
        vecs.push_back(mk(ADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1));
        vecs.push_back(mk(SUB,    32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1010, 1));
        vecs.push_back(mk(SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1));
        vecs.push_back(mk(SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100, 1));
        vecs.push_back(mk(ADD,    32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1));
        vecs.push_back(mk(SUB,    32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001, 1));
        vecs.push_back(mk(SRA,    32'h80000000, 32'h00000004, 32'hF8000000, 4'b1000, 1));
        vecs.push_back(mk(SRL,    32'h80000000, 32'h00000024, 32'h08000000, 4'b0000, 1));
        vecs.push_back(mk(SLL,    32'h00000001, 32'h0000001F, 32'h80000000, 4'b1000, 1));
        vecs.push_back(mk(XOR,    32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 1));
        vecs.push_back(mk(AND,    32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 1));
        vecs.push_back(mk(OR,     32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 4'b1000, 1));
        vecs.push_back(mk(5'd31,  32'h00000001, 32'h00000001, 32'h00000000, 4'b0100, 1));
        vecs.push_back(mk(MULH,   32'h80000000, 32'h80000000, 32'h40000000, 4'b0000, 33));
        vecs.push_back(mk(MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 4'b1000, 33));
        vecs.push_back(mk(MUL,    32'h12345678, 32'h00000010, 32'h23456780, 4'b0000, 33));
        vecs.push_back(mk(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1000, 33));
        vecs.push_back(mk(DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 4'b1000, 33));
        vecs.push_back(mk(REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 4'b1000, 33));
        vecs.push_back(mk(DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 33));
        vecs.push_back(mk(REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b0100, 33));
        vecs.push_back(mk(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1000, 33));
        vecs.push_back(mk(REMU,   32'h00000005, 32'h00000000, 32'h00000005, 4'b0000, 33));
        vecs.push_back(mk(DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 4'b0000, 33));

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset nzcv", flags(), 32'b0100);
        chk("reset busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].res, vecs[i].nzcv, vecs[i].lat);
        end

        // Four back-to-back ADDs with the consumer always ready
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.alu_ctrl  = ADD;
        bus.a         = 32'd0;
        bus.b         = 32'd10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("b2b%0d result", i), bus.result, 32'(i + 10));
            if (i < 3) bus.a = 32'(i + 1);
            else       bus.in_valid = 1'b0;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Consumer stalls for 3 cycles while the next request waits
        bus.in_valid = 1'b1;
        bus.alu_ctrl = ADD;
        bus.a        = 32'd3;
        bus.b        = 32'd4;
        @(negedge clk);
        bus.a = 32'd100;
        bus.b = 32'd100;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hold%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("hold%0d result", i), bus.result, 32'd7);
            chk($sformatf("hold%0d in_ready", i), 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("hold release out_valid", 32'(bus.out_valid), 32'd1);
        chk("hold release result", bus.result, 32'd200);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Flush a DIV in its 10th iteration cycle
        bus.in_valid = 1'b1;
        bus.alu_ctrl = DIV;
        bus.a        = 32'd100;
        bus.b        = 32'd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("div busy", 32'(bus.busy), 32'd1);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush busy", 32'(bus.busy), 32'd0);
        chk("flush out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush result kept", bus.result, 32'd200);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("flush no late out_valid", 32'(seen), 32'd0);

        // Reset in the middle of a MUL
        bus.in_valid = 1'b1;
        bus.alu_ctrl = MUL;
        bus.a        = 32'd3;
        bus.b        = 32'd5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset in_ready", 32'(bus.in_ready), 32'd1);
        chk("midreset out_valid", 32'(bus.out_valid), 32'd0);
        chk("midreset result", bus.result, 32'd0);
        chk("midreset nzcv", flags(), 32'b0100);
        chk("midreset busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        run_vec("post-reset mul", MUL, 32'd3, 32'd5, 32'd15, 4'b0000, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
